// File: rtl/dq_current_controller.sv
// Dual-axis (d/q) fixed-point PI current controller with back-calculation anti-windup and symmetric clamp.
// Optional omega*L cross-coupling feed-forward (XW/XC states) is enabled by defining DQ_DECOUPLING_EN.
module dq_current_controller #(
  parameter int N  = 16,
  parameter int F  = 12,
  parameter int IW = N + 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic                start,
  input  logic signed [N-1:0] i_d_ref,
  input  logic signed [N-1:0] i_d,
  input  logic signed [N-1:0] i_q_ref,
  input  logic signed [N-1:0] i_q,
  input  logic signed [N-1:0] kp,
  input  logic signed [N-1:0] ki,
  input  logic signed [N-1:0] kaw,
  input  logic signed [N-1:0] omega_e,
  input  logic signed [N-1:0] l_s,
  input  logic signed [N-1:0] v_lim,
  output logic signed [N-1:0] v_d,
  output logic signed [N-1:0] v_q,
  output logic                valid,
  output logic                busy,
  output logic                sat_d,
  output logic                sat_q
);

  localparam int EW = N + 1;
  // Working width for p/u/w: wide enough that no intermediate sum or product ever wraps.
  localparam int UW = 3 * N + 4;
  localparam logic signed [IW-1:0] IMAX = {1'b0, {(IW-1){1'b1}}};
  localparam logic signed [IW-1:0] IMIN = {1'b1, {(IW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_PROP, S_INTEG, S_XW, S_XC, S_SAT, S_AW
  } state_t;

  state_t r_state, w_next;
  logic   w_accept, w_abort, w_publish;

  logic signed [N-1:0]  r_dref, r_dfb, r_qref, r_qfb;
  logic signed [N-1:0]  r_kp, r_ki, r_kaw, r_vlim;
  logic signed [EW-1:0] r_e_d, r_e_q;
  logic signed [UW-1:0] r_p_d, r_p_q, r_u_d, r_u_q;
  logic signed [IW-1:0] r_int_d, r_int_q;
  logic signed [N-1:0]  r_vc_d, r_vc_q, r_v_d, r_v_q;
  logic signed [N-1:0]  w_vc_d, w_vc_q;
  logic                 r_satc_d, r_satc_q, r_sat_d, r_sat_q;
  logic                 r_valid, r_busy;
`ifdef DQ_DECOUPLING_EN
  logic signed [N-1:0]  r_omega, r_ls;
  logic signed [UW-1:0] r_w;
`else
  logic                 w_unused_ff;
  assign w_unused_ff = ^{omega_e, l_s};
`endif

  // (a * b) >>> F with a full-precision product; result always fits UW.
  function automatic logic signed [UW-1:0] mulsh(input logic signed [N-1:0] a,
                                                 input logic signed [UW-1:0] b);
    logic signed [N+UW-1:0] m;
    m = (N+UW)'(a) * (N+UW)'(b);
    m = m >>> F;
    return UW'(m);
  endfunction

  function automatic logic signed [N-1:0] clampv(input logic signed [UW-1:0] u,
                                                 input logic signed [N-1:0]  lim);
    if (u > UW'(lim))         return lim;
    else if (u < -(UW'(lim))) return -lim;
    else                      return N'(u);
  endfunction

  function automatic logic signed [IW-1:0] isat(input logic signed [UW-1:0] s);
    if (s > UW'(IMAX))      return IMAX;
    else if (s < UW'(IMIN)) return IMIN;
    else                    return IW'(s);
  endfunction

  assign w_vc_d = clampv(r_u_d, r_vlim);
  assign w_vc_q = clampv(r_u_q, r_vlim);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_abort   = 1'b0;
    w_publish = 1'b0;
    if (r_state != S_IDLE && !en) begin
      w_abort = 1'b1;
      w_next  = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start && en) begin
          w_accept = 1'b1;
          w_next   = S_ERR;
        end
        S_ERR:   w_next = S_PROP;
        S_PROP:  w_next = S_INTEG;
`ifdef DQ_DECOUPLING_EN
        S_INTEG: w_next = S_XW;
`else
        S_INTEG: w_next = S_SAT;
`endif
        S_XW:    w_next = S_XC;
        S_XC:    w_next = S_SAT;
        S_SAT:   w_next = S_AW;
        S_AW: begin
          w_publish = 1'b1;
          w_next    = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Inputs are snapshotted on the accepting edge; each state then does its step one edge later.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_dref   <= '0; r_dfb <= '0; r_qref <= '0; r_qfb <= '0;
      r_kp     <= '0; r_ki  <= '0; r_kaw  <= '0; r_vlim <= '0;
      r_e_d    <= '0; r_e_q <= '0;
      r_p_d    <= '0; r_p_q <= '0; r_u_d  <= '0; r_u_q  <= '0;
      r_int_d  <= '0; r_int_q <= '0;
      r_vc_d   <= '0; r_vc_q  <= '0; r_v_d <= '0; r_v_q <= '0;
      r_satc_d <= 1'b0; r_satc_q <= 1'b0; r_sat_d <= 1'b0; r_sat_q <= 1'b0;
`ifdef DQ_DECOUPLING_EN
      r_omega  <= '0; r_ls <= '0; r_w <= '0;
`endif
    end else if (w_accept) begin
      r_dref <= i_d_ref;
      r_dfb  <= i_d;
      r_qref <= i_q_ref;
      r_qfb  <= i_q;
      r_kp   <= kp;
      r_ki   <= ki;
      r_kaw  <= kaw;
      r_vlim <= v_lim[N-1] ? '0 : v_lim;
`ifdef DQ_DECOUPLING_EN
      r_omega <= omega_e;
      r_ls    <= l_s;
`endif
    end else if (!w_abort) begin
      case (r_state)
        S_ERR: begin
          r_e_d <= EW'(r_dref) - EW'(r_dfb);
          r_e_q <= EW'(r_qref) - EW'(r_qfb);
        end
        S_PROP: begin
          r_p_d <= mulsh(r_kp, UW'(r_e_d));
          r_p_q <= mulsh(r_kp, UW'(r_e_q));
        end
        S_INTEG: begin
          r_u_d <= r_p_d + UW'(r_int_d);
          r_u_q <= r_p_q + UW'(r_int_q);
        end
`ifdef DQ_DECOUPLING_EN
        S_XW: r_w <= mulsh(r_omega, UW'(r_ls));
        S_XC: begin
          r_u_d <= r_u_d - mulsh(r_qfb, r_w);
          r_u_q <= r_u_q + mulsh(r_dfb, r_w);
        end
`endif
        S_SAT: begin
          r_vc_d   <= w_vc_d;
          r_vc_q   <= w_vc_q;
          r_satc_d <= (UW'(w_vc_d) != r_u_d);
          r_satc_q <= (UW'(w_vc_q) != r_u_q);
        end
        S_AW: begin
          r_int_d <= isat(UW'(r_int_d) + mulsh(r_ki, UW'(r_e_d))
                          + mulsh(r_kaw, UW'(r_vc_d) - r_u_d));
          r_int_q <= isat(UW'(r_int_q) + mulsh(r_ki, UW'(r_e_q))
                          + mulsh(r_kaw, UW'(r_vc_q) - r_u_q));
          r_v_d   <= r_vc_d;
          r_v_q   <= r_vc_q;
          r_sat_d <= r_satc_d;
          r_sat_q <= r_satc_q;
        end
        default: ;
      endcase
    end
  end

  // busy stays up through the valid cycle, then drops unless a new start is taken.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= w_publish;
      if (w_accept)     r_busy <= 1'b1;
      else if (w_abort) r_busy <= 1'b0;
      else if (r_valid) r_busy <= 1'b0;
    end
  end

  assign v_d   = r_v_d;
  assign v_q   = r_v_q;
  assign sat_d = r_sat_d;
  assign sat_q = r_sat_q;
  assign valid = r_valid;
  assign busy  = r_busy;

endmodule

// File: tb/tb_dq_current_controller.sv
// Self-checking bench for dq_current_controller: directed literal cases plus randomized traffic
// against a sample-level arithmetic model; honours DQ_DECOUPLING_EN.
module tb_dq_current_controller;
  localparam int N  = 16;
  localparam int F  = 12;
  localparam int IW = N + 4;
`ifdef DQ_DECOUPLING_EN
  localparam int L   = 7;
  localparam bit DEC = 1'b1;
`else
  localparam int L   = 5;
  localparam bit DEC = 1'b0;
`endif

  logic clk = 1'b0, nrst = 1'b0, en = 1'b0, start = 1'b0;
  logic signed [N-1:0] i_d_ref = '0, i_d = '0, i_q_ref = '0, i_q = '0;
  logic signed [N-1:0] kp = '0, ki = '0, kaw = '0, omega_e = '0, l_s = '0, v_lim = '0;
  logic signed [N-1:0] v_d, v_q;
  logic valid, busy, sat_d, sat_q;

  always #5 clk = ~clk;

  dq_current_controller #(.N(N), .F(F), .IW(IW)) dut (
    .clk(clk), .nrst(nrst), .en(en), .start(start),
    .i_d_ref(i_d_ref), .i_d(i_d), .i_q_ref(i_q_ref), .i_q(i_q),
    .kp(kp), .ki(ki), .kaw(kaw), .omega_e(omega_e), .l_s(l_s), .v_lim(v_lim),
    .v_d(v_d), .v_q(v_q), .valid(valid), .busy(busy), .sat_d(sat_d), .sat_q(sat_q)
  );

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (one sample = one arithmetic evaluation) ----------------
  int     m_cnt = 0;
  longint m_id = 0, m_iq = 0;
  logic signed [N-1:0] m_vd = '0, m_vq = '0;
  bit     m_sd = 1'b0, m_sq = 1'b0, m_valid = 1'b0;
  longint c_dref, c_dfb, c_qref, c_qfb, c_kp, c_ki, c_kaw, c_om, c_ls, c_vlim;

  function automatic longint fl(input longint a, input longint b);
    return (a * b) >>> F;
  endfunction

  function automatic longint clip(input longint x, input longint lim);
    if (x > lim)  return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  function automatic longint isat(input longint x);
    longint hi, lo;
    hi = (longint'(1) <<< (IW - 1)) - 1;
    lo = -(longint'(1) <<< (IW - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model_step();
    longint ed, eq, ud, uq, w, lim, vd, vq;
    ed = c_dref - c_dfb;
    eq = c_qref - c_qfb;
    ud = fl(c_kp, ed) + m_id;
    uq = fl(c_kp, eq) + m_iq;
    if (DEC) begin
      w  = fl(c_om, c_ls);
      ud = ud - fl(w, c_qfb);
      uq = uq + fl(w, c_dfb);
    end
    lim  = (c_vlim < 0) ? 0 : c_vlim;
    vd   = clip(ud, lim);
    vq   = clip(uq, lim);
    m_sd = (vd != ud);
    m_sq = (vq != uq);
    m_vd = vd[N-1:0];
    m_vq = vq[N-1:0];
    m_id = isat(m_id + fl(c_ki, ed) + fl(c_kaw, vd - ud));
    m_iq = isat(m_iq + fl(c_ki, eq) + fl(c_kaw, vq - uq));
  endtask

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_cnt = 0; m_id = 0; m_iq = 0; m_vd = '0; m_vq = '0;
      m_sd = 1'b0; m_sq = 1'b0; m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_cnt > 0) begin
        if (!en) m_cnt = 0;
        else begin
          m_cnt--;
          if (m_cnt == 0) begin
            model_step();
            m_valid = 1'b1;
          end
        end
      end else if (start && en) begin
        c_dref = i_d_ref; c_dfb = i_d; c_qref = i_q_ref; c_qfb = i_q;
        c_kp = kp; c_ki = ki; c_kaw = kaw; c_om = omega_e; c_ls = l_s; c_vlim = v_lim;
        m_cnt = L;
      end
    end
  end

  always @(negedge clk) begin
    cmp("valid", valid, m_valid);
    cmp("busy", busy, ((m_cnt > 0) || m_valid) ? 1 : 0);
    cmp("v_d", v_d, m_vd);
    cmp("v_q", v_q, m_vq);
    cmp("sat_d", sat_d, m_sd);
    cmp("sat_q", sat_q, m_sq);
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_sample(output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!valid && lat < 4 * L) begin
      @(negedge clk);
      lat++;
    end
    cmp("valid_timeout", valid, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic set_in(input int dref, input int dfb, input int qref, input int qfb,
                        input int p, input int i, input int aw, input int om, input int ls,
                        input int lim);
    i_d_ref = N'(dref); i_d = N'(dfb); i_q_ref = N'(qref); i_q = N'(qfb);
    kp = N'(p); ki = N'(i); kaw = N'(aw); omega_e = N'(om); l_s = N'(ls); v_lim = N'(lim);
  endtask

  function automatic logic signed [N-1:0] rv(input bit full);
    logic [31:0] r;
    r = $urandom;
    if (full) return r[N-1:0];
    return N'(int'(r % 8192) - 4096);
  endfunction

  initial begin
    int n;
    int seen;
    en = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 30000);
    repeat (3) @(negedge clk);
    cmp("rst_v_d", v_d, 0);
    cmp("rst_valid", valid, 0);
    cmp("rst_busy", busy, 0);
    nrst = 1'b1;
    @(negedge clk);

    // proportional only
    set_in(1000, 0, 0, 0, 4096, 0, 0, 0, 0, 30000);
    run_sample(n);
    cmp("p_latency", n, L);
    cmp("p_v_d", v_d, 1000);
    cmp("p_v_q", v_q, 0);
    cmp("pin_model_p", m_vd, 1000);
    @(negedge clk);
    cmp("p_valid_width", valid, 0);

    // integral ramp, back-to-back at the maximum start rate
    set_in(4096, 0, 0, 0, 0, 410, 0, 0, 0, 30000);
    for (int k = 0; k < 4; k++) begin
      run_sample(n);
      cmp($sformatf("int_v_d%0d", k), v_d, 410 * k);
      cmp($sformatf("int_lat%0d", k), n, L);
    end

    // asynchronous reset in the middle of a sample
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    cmp("arst_v_d", v_d, 0);
    cmp("arst_valid", valid, 0);
    cmp("arst_busy", busy, 0);
    cmp("arst_sat_d", sat_d, 0);
    @(negedge clk);
    nrst = 1'b1;
    seen = 0;
    repeat (2 * L) begin
      @(negedge clk);
      seen += int'(valid);
    end
    cmp("arst_no_valid", seen, 0);

    // clamp plus back-calculation anti-windup
    set_in(4096, 0, 0, 0, 4096, 0, 4096, 0, 0, 2000);
    run_sample(n);
    cmp("clamp1_v_d", v_d, 2000);
    cmp("clamp1_sat_d", sat_d, 1);
    cmp("pin_model_int", m_id, -2096);
    run_sample(n);
    cmp("clamp2_v_d", v_d, 2000);
    cmp("clamp2_sat_d", sat_d, 0);
    set_in(4096, 0, 0, 0, 0, 0, 4096, 0, 0, 30000);
    run_sample(n);
    cmp("clamp3_v_d", v_d, -2096);

    // handshake: second start while busy is dropped
    do_reset();
    set_in(300, 0, 0, 0, 4096, 0, 0, 0, 0, 30000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (3 * L) begin
      @(negedge clk);
      seen += int'(valid);
    end
    cmp("hs_single_valid", seen, 1);
    cmp("hs_v_d", v_d, 300);

    // enable dropped mid-sample
    set_in(777, 0, 0, 0, 4096, 0, 0, 0, 0, 30000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    seen = 0;
    repeat (2 * L) begin
      @(negedge clk);
      seen += int'(valid);
    end
    cmp("abort_no_valid", seen, 0);
    cmp("abort_v_d_held", v_d, 300);
    cmp("abort_busy", busy, 0);

    // cross-coupling feed-forward
    do_reset();
    set_in(0, 0, 0, 1000, 0, 0, 0, 4096, 2048, 30000);
    run_sample(n);
    cmp("dec_latency", n, L);
    cmp("dec_v_d", v_d, DEC ? -500 : 0);
    cmp("dec_v_q", v_q, 0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        bit full;
        full    = ($urandom_range(0, 3) == 0);
        i_d_ref = rv(full); i_d = rv(full); i_q_ref = rv(full); i_q = rv(full);
        kp  = rv(full); ki = rv(full); kaw = rv(full);
        omega_e = rv(full); l_s = rv(full);
        v_lim = ($urandom_range(0, 9) == 0) ? rv(1'b1) : N'($urandom_range(0, 32767));
      end
      start = ($urandom_range(0, 2) == 0);
      en    = ($urandom_range(0, 24) != 0);
    end
    @(negedge clk);
    start = 1'b0;
    en    = 1'b1;
    repeat (2 * L + 2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
